// File: rtl/quad_pkg.sv
// Shared types and phase tables for the quadrature decoder.
package quad_pkg;

  typedef enum logic [1:0] {
    MODE_X1 = 2'd0,
    MODE_X2 = 2'd1,
    MODE_X4 = 2'd2
  } mode_e;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } fsm_e;

  typedef logic [1:0] phase_t;

  // Clockwise successor of each {a,b} phase.
  localparam phase_t CW_NEXT_00 = 2'b01;
  localparam phase_t CW_NEXT_01 = 2'b11;
  localparam phase_t CW_NEXT_11 = 2'b10;
  localparam phase_t CW_NEXT_10 = 2'b00;

  function automatic phase_t cw_next(input phase_t p);
    phase_t n;
    case (p)
      2'b00:   n = CW_NEXT_00;
      2'b01:   n = CW_NEXT_01;
      2'b11:   n = CW_NEXT_11;
      default: n = CW_NEXT_10;
    endcase
    return n;
  endfunction

  function automatic mode_e decode_mode(input logic [1:0] m);
    mode_e d;
    case (m)
      2'b00:   d = MODE_X1;
      2'b01:   d = MODE_X2;
      default: d = MODE_X4;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Synchroniser plus debounce for one encoder channel; reports the accepted
// level and whether the whole input path currently agrees with it.
module quad_filter #(
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filt,
  output logic settled
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Settled also requires the synchroniser chain to agree, so a pin level
  // still in flight after reset is not mistaken for a quiet input.
  assign settled = (cnt_q == '0) && (sync_q == {SYNC_STAGES{filt}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      if (s == filt) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt  <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered a/b phases decoded into step pulses, a wrapping
// position counter and illegal-transition flags.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             cw,
  output logic             ccw,
  output logic             dir,
  output logic [CNT_W-1:0] pos,
  output logic             err,
  output logic             err_sticky
);

  // At least two quiet cycles so the first post-reset pin sample is seen.
  localparam int unsigned SETTLE_N = (FILT_LEN < 2) ? 2 : FILT_LEN;
  localparam int unsigned SW       = $clog2(SETTLE_N + 1);

  logic   f_a, f_b, set_a, set_b;
  fsm_e   state;
  phase_t prev, cur;
  logic [SW-1:0] settle_cnt;
  logic   step_cw, step_ccw, dbl, counted, err_now;
  mode_e  mode_d;

  quad_filter #(.FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .pin(a), .filt(f_a), .settled(set_a)
  );

  quad_filter #(.FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .pin(b), .filt(f_b), .settled(set_b)
  );

  always_comb begin
    cur      = {f_a, f_b};
    mode_d   = decode_mode(mode);
    step_cw  = (cur == cw_next(prev));
    step_ccw = (prev == cw_next(cur));
    dbl      = ((cur ^ prev) == 2'b11);
    counted  = 1'b1;
    case (mode_d)
      MODE_X1: counted = (cur == 2'b00);
      MODE_X2: counted = (cur[1] != prev[1]);
      default: counted = 1'b1;
    endcase
    err_now  = (state == TRACK) && dbl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      settle_cnt <= '0;
      prev       <= '0;
      cw         <= 1'b0;
      ccw        <= 1'b0;
      dir        <= 1'b0;
      pos        <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      cw   <= 1'b0;
      ccw  <= 1'b0;
      prev <= cur;
      case (state)
        INIT: begin
          if (set_a && set_b) begin
            if (settle_cnt == SW'(SETTLE_N - 1)) state <= TRACK;
            else settle_cnt <= settle_cnt + SW'(1);
          end else begin
            settle_cnt <= '0;
          end
        end
        TRACK: begin
          if (!dbl && (step_cw || step_ccw) && counted) begin
            cw  <= step_cw;
            ccw <= step_ccw;
            dir <= step_cw;
            pos <= step_cw ? pos + CNT_W'(1) : pos - CNT_W'(1);
          end
        end
        default: state <= INIT;
      endcase
      // clr overrides the count update above; a same-cycle error still sets.
      if (clr) pos <= '0;
      err        <= err_now;
      err_sticky <= err_now | (err_sticky & ~clr);
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus random encoder motion,
// checked every cycle against a pin-history reference model.
module tb_quad_decoder;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned FILT_LEN    = 3;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned QUIET       = 20;
  localparam int unsigned TRACK_AFTER = 12;
  localparam int unsigned WIN_MASK    = (1 << FILT_LEN) - 1;
  localparam int unsigned POS_MOD     = 1 << CNT_W;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             a = 1'b0, b = 1'b0, clr = 1'b0;
  logic [1:0]       mode = 2'd2;
  logic             cw, ccw, dir, err, err_sticky;
  logic [CNT_W-1:0] pos;

  quad_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode), .clr(clr),
    .cw(cw), .ccw(ccw), .dir(dir), .pos(pos), .err(err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned errors = 0, checks = 0;
  int unsigned n_cw = 0, n_ccw = 0, n_err = 0;
  int unsigned last_cw_cyc = 0, last_ccw_cyc = 0, mv_cyc = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Position of a phase around the cycle 00 -> 01 -> 11 -> 10 (CW direction).
  function automatic int unsigned ring_idx(input bit [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit [1:0] ring_at(input int unsigned i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Reference model: pin history; a channel accepts a new level once the
  // delayed pin has disagreed with it for FILT_LEN samples in a row.
  int unsigned hist[2];
  bit          mf[2];
  bit [1:0]    m_prev, m_cur;
  bit          m_track;
  int unsigned m_age, d, win;
  bit          cnt_it;
  bit          e_cw, e_ccw, e_dir, e_err, e_sticky;
  int unsigned e_pos;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      hist[0] = 0; hist[1] = 0; mf[0] = 0; mf[1] = 0;
      m_prev = 2'b00; m_track = 0; m_age = 0;
      e_cw = 0; e_ccw = 0; e_dir = 0; e_err = 0; e_sticky = 0; e_pos = 0;
    end else begin
      m_cur = {mf[0], mf[1]};
      e_cw = 0; e_ccw = 0; e_err = 0;
      if (m_track && m_cur != m_prev) begin
        d = (ring_idx(m_cur) + 4 - ring_idx(m_prev)) % 4;
        if (d == 2) begin
          e_err = 1;
        end else begin
          if (mode == 2'd0)      cnt_it = (m_cur == 2'b00);
          else if (mode == 2'd1) cnt_it = (m_cur[1] != m_prev[1]);
          else                   cnt_it = 1;
          if (cnt_it) begin
            e_cw  = (d == 1);
            e_ccw = (d == 3);
            e_dir = (d == 1);
            e_pos = (e_pos + ((d == 1) ? 1 : POS_MOD - 1)) % POS_MOD;
          end
        end
      end
      if (clr) begin e_pos = 0; e_sticky = 0; end
      if (e_err) e_sticky = 1;
      m_prev = m_cur;
      m_age++;
      if (m_age >= TRACK_AFTER) m_track = 1;
      hist[0] = (hist[0] << 1) | int'(a);
      hist[1] = (hist[1] << 1) | int'(b);
      for (int ch = 0; ch < 2; ch++) begin
        win = (hist[ch] >> SYNC_STAGES) & WIN_MASK;
        if (mf[ch] ? (win == 0) : (win == WIN_MASK)) mf[ch] = ~mf[ch];
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("cw", cw, e_cw);
    chk("ccw", ccw, e_ccw);
    chk("dir", dir, e_dir);
    chk("pos", pos, e_pos);
    chk("err", err, e_err);
    chk("err_sticky", err_sticky, e_sticky);
    if (cw)  begin n_cw++;  last_cw_cyc  = cyc; end
    if (ccw) begin n_ccw++; last_ccw_cyc = cyc; end
    if (err) n_err++;
  end

  task automatic mv(input bit na, input bit nb, input int unsigned hold);
    @(negedge clk);
    a = na; b = nb; mv_cyc = cyc;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  int unsigned base_cw, base_ccw, base_err, hold;
  bit [1:0]    cur_p, nxt;
  int unsigned r;

  initial begin
    // 1: encoder resting at 11 through reset
    a = 1'b1; b = 1'b1; mode = 2'd2;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (QUIET) @(negedge clk);
    chk("t1_no_pulses", n_cw + n_ccw + n_err, 0);
    chk("t1_pos", pos, 0);
    mv(1, 0, 10); mv(0, 0, 10);
    chk("t1_walk_pos", pos, 2);
    clr_pulse();
    chk("t1_clr_pos", pos, 0);

    // 2: x4, two full CW cycles, fixed latency per step
    base_cw = n_cw;
    for (int unsigned i = 1; i <= 8; i++) begin
      nxt = ring_at(i);
      mv(nxt[1], nxt[0], 10);
      chk("t2_latency", last_cw_cyc - mv_cyc, SYNC_STAGES + FILT_LEN + 1);
    end
    chk("t2_cw_count", n_cw - base_cw, 8);
    chk("t2_pos", pos, 8);
    chk("t2_dir", dir, 1);

    // 3: x1, one CCW cycle wraps to all ones
    clr_pulse();
    mode = 2'd0;
    base_ccw = n_ccw;
    mv(1, 0, 10); mv(1, 1, 10); mv(0, 1, 10); mv(0, 0, 10);
    chk("t3_ccw_count", n_ccw - base_ccw, 1);
    chk("t3_latency", last_ccw_cyc - mv_cyc, SYNC_STAGES + FILT_LEN + 1);
    chk("t3_pos_wrap", pos, 255);
    chk("t3_dir", dir, 0);

    // 4: glitch shorter than the filter vs. exactly the filter length
    mode = 2'd2;
    base_cw = n_cw; base_ccw = n_ccw;
    mv(1, 0, 2); mv(0, 0, 10);
    chk("t4_glitch_pulses", (n_cw - base_cw) + (n_ccw - base_ccw), 0);
    chk("t4_glitch_pos", pos, 255);
    mv(0, 1, 3); mv(0, 0, 12);
    chk("t4_min_cw", n_cw - base_cw, 1);
    chk("t4_min_ccw", n_ccw - base_ccw, 1);
    chk("t4_min_pos", pos, 255);

    // 5: double-bit change flags an error, then clr
    base_err = n_err;
    mv(1, 1, 10);
    chk("t5_err_count", n_err - base_err, 1);
    chk("t5_sticky", err_sticky, 1);
    chk("t5_pos", pos, 255);
    mv(1, 0, 10); mv(0, 0, 10);
    chk("t5_pos_after", pos, 1);
    clr_pulse();
    chk("t5_sticky_clr", err_sticky, 0);
    chk("t5_pos_clr", pos, 0);

    // 6: x2 counts only a-edges; clr coincident with a counted step
    mode = 2'd1;
    base_cw = n_cw;
    mv(0, 1, 10); mv(1, 1, 10); mv(1, 0, 10); mv(0, 0, 10);
    chk("t6_pos", pos, 2);
    chk("t6_cw_count", n_cw - base_cw, 2);
    mv(0, 1, 10);
    @(negedge clk);
    a = 1'b1; b = 1'b1;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_clr_cw", cw, 1);
    chk("t6_clr_pos", pos, 0);
    chk("t6_clr_dir", dir, 1);
    @(negedge clk); clr = 1'b0;
    repeat (10) @(negedge clk);

    // 7: random motion, glitches, illegal jumps, mode changes and clears
    for (int i = 0; i < 300; i++) begin
      cur_p = {a, b};
      r = $urandom % 16;
      if (r == 0)     nxt = ~cur_p;
      else if (r < 9) nxt = ring_at(ring_idx(cur_p) + 1);
      else            nxt = ring_at(ring_idx(cur_p) + 3);
      @(negedge clk);
      a = nxt[1]; b = nxt[0];
      clr = ($urandom % 20 == 0);
      if ($urandom % 10 == 0) mode = 2'($urandom % 4);
      hold = $urandom_range(1, 12);
      @(negedge clk);
      clr = 1'b0;
      repeat (hold - 1) @(negedge clk);
    end

    // 8: asynchronous reset mid-run
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_pos", pos, 0);
    chk("t8_rst_flags", {cw, ccw, dir, err, err_sticky}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (QUIET) @(negedge clk);
    mode = 2'd2;
    for (int i = 0; i < 40; i++) begin
      nxt = ring_at(ring_idx({a, b}) + (($urandom % 2 == 0) ? 1 : 3));
      mv(nxt[1], nxt[0], $urandom_range(2, 10));
    end
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
